// File: rtl/product_accumulator.sv
// Accumulates a frame of signed Booth products with saturation, then streams the
// clamped sum out LSB byte first over a valid/ack handshake.
module product_accumulator #(
  parameter int unsigned ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] prod,
  input  logic        prod_ready,
  input  logic [3:0]  count_n,
  input  logic        clr,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ack,
  output logic        busy,
  output logic        overrun,
  output logic        sat
);

  localparam int unsigned NB    = ACC_W / 8;
  localparam int unsigned IDX_W = $clog2(NB + 1);
  localparam int unsigned CNT_W = 5;
  localparam int unsigned EXT_W = ACC_W - 15;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] SEND  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nlat_q, nlat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pr_q, pr_d;
  logic             armed_q, armed_d;
  logic             overrun_q, overrun_d;
  logic             sat_q, sat_d;

  logic             cap;
  logic [CNT_W-1:0] n_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W:0]   sum_w;
  logic             ovf;
  logic [ACC_W-1:0] clamped;

  // Edge detect; armed_q blocks a level that was already high when reset released.
  assign cap     = prod_ready & ~pr_q & armed_q;
  assign n_eff   = (cnt_q == '0) ? ((count_n == 4'd0) ? CNT_W'(16) : CNT_W'(count_n)) : nlat_q;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // One guard bit: overflow shows as disagreement of the top two sum bits.
  assign sum_w   = {acc_q[ACC_W-1], acc_q} + {{EXT_W{prod[15]}}, prod};
  assign ovf     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  assign clamped = !ovf ? sum_w[ACC_W-1:0] :
                   sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    nlat_d    = nlat_q;
    idx_d     = idx_q;
    pr_d      = prod_ready;
    armed_d   = armed_q | ~prod_ready;
    overrun_d = overrun_q;
    sat_d     = sat_q;

    if (clr) begin
      state_d   = ACCUM;
      acc_d     = '0;
      shift_d   = '0;
      cnt_d     = '0;
      idx_d     = '0;
      overrun_d = 1'b0;
      sat_d     = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (cap) begin
            nlat_d = n_eff;
            if (ovf) sat_d = 1'b1;
            if (cnt_inc == n_eff) begin
              shift_d = clamped;
              acc_d   = '0;
              cnt_d   = '0;
              idx_d   = '0;
              state_d = SEND;
            end else begin
              acc_d = clamped;
              cnt_d = cnt_inc;
            end
          end
        end
        SEND: begin
          if (cap) overrun_d = 1'b1;
          if (byte_ack) begin
            if (idx_q == IDX_W'(NB - 1)) begin
              shift_d = '0;
              idx_d   = '0;
              state_d = ACCUM;
            end else begin
              shift_d = shift_q >> 8;
              idx_d   = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      nlat_q    <= '0;
      idx_q     <= '0;
      pr_q      <= 1'b0;
      armed_q   <= 1'b0;
      overrun_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      nlat_q    <= nlat_d;
      idx_q     <= idx_d;
      pr_q      <= pr_d;
      armed_q   <= armed_d;
      overrun_q <= overrun_d;
      sat_q     <= sat_d;
    end
  end

  assign byte_valid = (state_q == SEND);
  assign busy       = byte_valid;
  assign byte_out   = byte_valid ? shift_q[7:0] : 8'h00;
  assign overrun    = overrun_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed corner cases plus random frames on a
// 24-bit and a 16-bit instance, checked against an arithmetic frame model.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst, clr, pr, ack, sel;
  logic [15:0] prod;
  logic [3:0]  count_n;

  logic [7:0]  bo24, bo16;
  logic        bv24, bv16, busy24, busy16, ovr24, ovr16, sat24, sat16;
  logic        pr24, pr16, ack24, ack16;
  logic [7:0]  bo;
  logic        bv, busy, ovr, sat;

  int errors = 0;
  int checks = 0;
  bit sat_m  = 1'b0;
  logic signed [15:0] pv [16];

  always #5 clk = ~clk;

  // sel steers prod_ready/byte_ack to one instance and picks its outputs.
  assign pr24  = pr & ~sel;
  assign pr16  = pr & sel;
  assign ack24 = ack & ~sel;
  assign ack16 = ack & sel;
  assign bo    = sel ? bo16 : bo24;
  assign bv    = sel ? bv16 : bv24;
  assign busy  = sel ? busy16 : busy24;
  assign ovr   = sel ? ovr16 : ovr24;
  assign sat   = sel ? sat16 : sat24;

  product_accumulator #(.ACC_W(24)) dut (
    .clk(clk), .rst(rst), .prod(prod), .prod_ready(pr24), .count_n(count_n),
    .clr(clr), .byte_out(bo24), .byte_valid(bv24), .byte_ack(ack24),
    .busy(busy24), .overrun(ovr24), .sat(sat24)
  );

  product_accumulator #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .prod(prod), .prod_ready(pr16), .count_n(count_n),
    .clr(clr), .byte_out(bo16), .byte_valid(bv16), .byte_ack(ack16),
    .busy(busy16), .overrun(ovr16), .sat(sat16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] p, input int hold, input bit last);
    prod = p;
    pr   = 1'b1;
    tick();
    if (last) check("busy_rise", 32'(busy), 32'd1);
    repeat (hold - 1) tick();
    pr = 1'b0;
    tick();
  endtask

  task automatic recv(input int nb, input longint v);
    logic [63:0] ev;
    int k;
    int d;
    ev = 64'(v);
    for (int b = 0; b < nb; b++) begin
      k = 0;
      while (!bv && k < 8) begin
        tick();
        k++;
      end
      check("byte_valid", 32'(bv), 32'd1);
      check("byte", 32'(bo), 32'(ev[8*b +: 8]));
      d = int'($urandom_range(0, 2));
      repeat (d) tick();
      if (d > 0) check("byte_hold", 32'(bo), 32'(ev[8*b +: 8]));
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    check("valid_drop", 32'(bv), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check("byte_zero", 32'(bo), 32'd0);
  endtask

  // Frame model: running signed sum clamped to w bits after every product.
  task automatic run_frame(input int n, input int w);
    longint a, lo, hi;
    a  = 0;
    lo = -(64'sd1 <<< (w - 1));
    hi = (64'sd1 <<< (w - 1)) - 1;
    count_n = 4'(n);
    for (int i = 0; i < n; i++) begin
      a = a + longint'(pv[i]);
      if (a > hi) begin a = hi; sat_m = 1'b1; end
      else if (a < lo) begin a = lo; sat_m = 1'b1; end
      pulse(pv[i], int'($urandom_range(1, 3)), i == n - 1);
      if (i == 0) count_n = 4'($urandom);
    end
    recv(w / 8, a);
    check("sat", 32'(sat), 32'(sat_m));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sat_m = 1'b0;
  endtask

  task automatic one(input logic [15:0] p, input int w);
    pv[0] = p;
    run_frame(1, w);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; pr = 1'b0; ack = 1'b0; sel = 1'b0;
    prod = '0; count_n = '0;
    #1;
    check("rst_valid", 32'(bv), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {30'd0, ovr, sat}, 32'd0);
    #11 rst = 1'b0;
    tick();

    // Single product frame.
    one(16'h0038, 24);

    // Two negatives: -7 + -8 = -15.
    pv[0] = 16'hFFF9; pv[1] = 16'hFFF8;
    run_frame(2, 24);

    // Level held high counts once; second pulse completes the frame.
    count_n = 4'd2;
    prod = 16'h0002; pr = 1'b1;
    repeat (5) tick();
    pr = 1'b0;
    tick();
    check("held_no_send", 32'(busy), 32'd0);
    pulse(16'h0002, 1, 1'b1);
    recv(3, 64'sd4);

    // Capture during SEND is dropped and flagged.
    count_n = 4'd1;
    pulse(16'h0010, 1, 1'b1);
    pulse(16'h0020, 2, 1'b0);
    check("overrun_set", 32'(ovr), 32'd1);
    check("overrun_byte", 32'(bo), 32'h10);
    recv(3, 64'sd16);
    one(16'h0003, 24);
    check("overrun_sticky", 32'(ovr), 32'd1);
    do_clr();
    check("overrun_clr", 32'(ovr), 32'd0);

    // Clear coinciding with a capture wins.
    count_n = 4'd1; prod = 16'h0050; pr = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; pr = 1'b0;
    tick();
    check("clr_vs_cap", 32'(busy), 32'd0);
    one(16'h0005, 24);

    // Async reset while byte 1 of 3 pending.
    count_n = 4'd1;
    pulse(16'h1234, 1, 1'b1);
    ack = 1'b1; tick(); ack = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_abort_valid", 32'(bv), 32'd0);
    check("rst_abort_flags", {30'd0, ovr, sat}, 32'd0);
    #2 rst = 1'b0;
    sat_m = 1'b0;
    tick();
    one(16'h0001, 24);

    // Clear while byte 1 of 3 pending.
    count_n = 4'd1;
    pulse(16'h1234, 1, 1'b1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("pre_clr_valid", 32'(bv), 32'd1);
    ack = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0; ack = 1'b0;
    check("clr_abort_valid", 32'(bv), 32'd0);
    check("clr_abort_flags", {30'd0, ovr, sat}, 32'd0);
    one(16'h0001, 24);

    // prod_ready high across reset release must not capture.
    count_n = 4'd1; prod = 16'h0077; pr = 1'b1;
    rst = 1'b1; #3 rst = 1'b0;
    repeat (3) tick();
    check("stale_level", 32'(busy), 32'd0);
    pr = 1'b0;
    tick();
    one(16'h0077, 24);

    // 16-bit instance: positive and negative saturation, sticky until clear.
    sel = 1'b1;
    pv[0] = 16'h7FFF; pv[1] = 16'h7FFF;
    run_frame(2, 16);
    one(16'h0004, 16);
    pv[0] = 16'h8000; pv[1] = 16'h8000;
    run_frame(2, 16);
    do_clr();
    check("sat_clr", 32'(sat), 32'd0);

    // Random frames on both widths.
    for (int f = 0; f < 16; f++) begin
      int n;
      sel = (f >= 8);
      n = int'($urandom_range(1, 16));
      for (int i = 0; i < 16; i++) pv[i] = 16'($urandom);
      run_frame(n, sel ? 16 : 24);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24, giving the accumulator width in bits; legal values are multiples of 8 and at least 16; NB = ACC_W/8 is the number of bytes per result.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port prod  input  16  signed two's-complement product from the upstream radix-4 Booth multiplier.
REQ-005 Port prod_ready  input  1  multiplier done level; it stays high while the product is held.
REQ-006 Port count_n  input  4  products per frame; 0 means 16.
REQ-007 Port clr  input  1  synchronous clear of the accumulator, counters, flags and any frame in flight.
REQ-008 Port byte_out  output  8  result byte, LSB byte first.
REQ-009 Port byte_valid  output  1  byte_out is valid.
REQ-010 Port byte_ack  input  1  consumer accepts byte_out.
REQ-011 Port busy  output  1  high while a result is being sent.
REQ-012 Port overrun  output  1  sticky flag: a product arrived while sending and was dropped.
REQ-013 Port sat  output  1  sticky flag: the accumulator clamped at least once.

Function
REQ-014 The block SHALL capture a product only on a rising edge of prod_ready: prod_ready=1 with the previous-cycle registered prod_ready=0. A held-high level SHALL yield exactly one capture.
REQ-015 The FSM SHALL have two states, ACCUM and SEND, and reset to ACCUM.
REQ-016 On the first capture of a frame (cnt=0), count_n SHALL be latched as N_lat (0 maps to 16). N_lat SHALL be used for the rest of the frame.
REQ-017 Each capture in ACCUM SHALL do acc <= clamp(acc + sign_extend(prod)) and cnt <= cnt+1.
REQ-018 clamp SHALL limit the sum to the range [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Whenever clamping occurs, sat SHALL be set.
REQ-019 When a capture makes cnt equal N_lat, the same edge SHALL:
  - load the shift register with the clamped sum,
  - clear acc and cnt,
  - move the FSM to SEND.
REQ-020 In SEND:
  - byte_valid=1 and busy=1;
  - byte_out = shift[7:0], held stable until byte_ack;
  - on byte_ack, the register shifts right 8 and the byte index increments.
REQ-021 The ack of byte NB-1 SHALL return the FSM to ACCUM. byte_valid SHALL be 0 in the following cycle.
REQ-022 A capture event while in SEND SHALL be discarded, SHALL set overrun, and SHALL leave acc and cnt unchanged.
REQ-023 byte_ack while byte_valid=0 SHALL be ignored.
REQ-024 clr=1 SHALL:
  - zero acc, cnt, shift register, byte index, overrun and sat;
  - force ACCUM, so a SEND in progress is aborted and byte_valid=0 next cycle.
REQ-025 clr and a capture in the same cycle: clr SHALL win and the product SHALL be discarded.
REQ-026 clr and byte_ack in the same cycle: clr SHALL win.
REQ-027 byte_out SHALL be 0 whenever byte_valid=0.
REQ-028 There SHALL be no combinational path from any input to any output, except byte_out/byte_valid, which are registered-state decodes.

Reset
REQ-029 rst=1 SHALL asynchronously force:
  - FSM=ACCUM;
  - acc, cnt, N_lat, shift register, byte index and prod_ready history = 0;
  - byte_out=0, byte_valid=0, busy=0, overrun=0, sat=0.
REQ-030 Reset asserted mid-frame or mid-SEND SHALL abandon the frame with no further bytes presented. A prod_ready already high at reset release SHALL count as a rising edge only if it was low in a sampled cycle after release.

Verification
REQ-031 count_n=1; prod=0x0038 with one prod_ready pulse. Required: busy rises next edge; bytes 0x38, 0x00, 0x00, each acked; then byte_valid=0 and busy=0.
REQ-032 count_n=2; products 0xFFF9 then 0xFFF8. Required: bytes 0xF1, 0xFF, 0xFF (sum -15); sat=0.
REQ-033 ACC_W=16, count_n=2; products 0x7FFF twice. Required: bytes 0xFF, 0x7F; sat=1 until clr.
REQ-034 prod_ready held high 5 cycles, count_n=2. Required: cnt=1 only, no SEND; a second pulse then triggers SEND.
REQ-035 Hold byte_ack=0 during SEND and pulse prod_ready. Required: overrun=1; byte_out unchanged; the sent value is unaffected; the next frame starts from acc=0.
REQ-036 Assert rst while byte 1 of 3 is pending, and separately pulse clr while byte 1 of 3 is pending. Required: byte_valid=0 (immediately for rst, next cycle for clr); all flags 0; a subsequent count_n=1, prod=0x0001 frame yields 0x01, 0x00, 0x00.
